// File: rtl/restoring_division_check_mult.sv
// -----------------------------------------------------------------------------
// restoring_division_check_mult
//
// Sequential shift-add multiply-accumulate that rebuilds the dividend of a
// restoring division: P = q*M + R. It handles one quotient bit per clock, so an
// operation always takes exactly N clocks after start is accepted.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, only looked at while idle
//   q      in   N      quotient (multiplier), captured with start
//   M      in   N+1    divisor (multiplicand), captured with start
//   R      in   N+1    remainder (addend), captured with start
//   P      out  2N+1   registered result, held until the next completion
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse when P is updated
// -----------------------------------------------------------------------------
module restoring_division_check_mult #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   q,
    input  logic [N:0]     M,
    input  logic [N:0]     R,
    output logic [2*N:0]   P,
    output logic           busy,
    output logic           done
);

    localparam int PW = 2 * N + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT           state_q, state_d;
    logic [N-1:0]    qShift_q, qShift_d;
    logic [PW-1:0]   mShift_q, mShift_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   result_q, result_d;
    logic            done_q, done_d;
    logic [PW-1:0]   accSum;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            qShift_q <= '0;
            mShift_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            qShift_q <= qShift_d;
            mShift_q <= mShift_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. The last RUN cycle publishes the sum that includes
    // that cycle's partial product, so P never misses the top quotient bit.
    always_comb begin
        state_d  = state_q;
        qShift_d = qShift_q;
        mShift_d = mShift_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;
        accSum   = qShift_q[0] ? (acc_q + mShift_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    qShift_d = q;
                    mShift_d = {{N{1'b0}}, M};
                    acc_d    = {{N{1'b0}}, R};
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = accSum;
                qShift_d = qShift_q >> 1;
                // Bits pushed off the top are never significant: the partial
                // products that would use them are already zero in q.
                mShift_d = mShift_q << 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    result_d = accSum;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        P    = result_q;
    end

endmodule

// File: tb/tb_restoring_division_check_mult.sv
// -----------------------------------------------------------------------------
// tb_restoring_division_check_mult
//
// Directed plus randomized bench for restoring_division_check_mult. Expected
// results come from plain arithmetic q*M + R.
// -----------------------------------------------------------------------------
module tb_restoring_division_check_mult;

    localparam int N = 5;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   q;
    logic [N:0]     M;
    logic [N:0]     R;
    logic [2*N:0]   P;
    logic           busy;
    logic           done;

    int passCount  = 0;
    int checkCount = 0;
    int cycleCount = 0;

    restoring_division_check_mult #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q     (q),
        .M     (M),
        .R     (R),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to measure latency in whole clocks.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic int refP(input int qv, input int mv, input int rv);
        return qv * mv + rv;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Present operands with start for one clock; returns the edge number at
    // which start is sampled. Returns at the falling edge after that edge.
    task automatic applyStimulus(input logic [N-1:0] qv, input logic [N:0] mv,
                                 input logic [N:0] rv, output int acceptEdge);
        @(negedge clk);
        q = qv;
        M = mv;
        R = rv;
        start = 1'b1;
        acceptEdge = cycleCount + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting falling edges on which busy was high.
    task automatic waitDone(input string tag, output int doneEdge, output int busyCount);
        int guard;
        guard = 0;
        busyCount = 0;
        while (done !== 1'b1 && guard < 100) begin
            if (busy === 1'b1) busyCount++;
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "/doneSeen"}, {31'd0, done}, 32'd1);
        doneEdge = cycleCount;
    endtask

    // Full operation with result, latency, busy length and done-width checks.
    task automatic runOp(input string tag, input int qv, input int mv, input int rv);
        int acceptEdge, doneEdge, busyCount, expected;
        expected = refP(qv, mv, rv);
        applyStimulus(qv[N-1:0], mv[N:0], rv[N:0], acceptEdge);
        waitDone(tag, doneEdge, busyCount);
        checkOutput({tag, "/P"}, {21'd0, P}, expected);
        checkOutput({tag, "/latency"}, doneEdge - acceptEdge, N);
        checkOutput({tag, "/busyCycles"}, busyCount, N);
        checkOutput({tag, "/busyAtDone"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "/donePulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "/Phold"}, {21'd0, P}, expected);
    endtask

    initial begin
        int k1, d1, d2, bc, doneSeen;
        int qv, mv, rv;

        rst = 1'b1;
        start = 1'b0;
        q = '0;
        M = '0;
        R = '0;

        #3;
        checkOutput("reset/P", {21'd0, P}, 32'd0);
        checkOutput("reset/busy", {31'd0, busy}, 32'd0);
        checkOutput("reset/done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle/P", {21'd0, P}, 32'd0);
        checkOutput("idle/busy", {31'd0, busy}, 32'd0);

        $display("[TB] basic and divider set");
        runOp("basic", 3, 3, 2);
        runOp("div1", 2, 7, 6);
        runOp("div2", 3, 5, 0);
        runOp("div3", 1, 9, 8);
        repeat (3) @(negedge clk);
        checkOutput("holdIdle/P", {21'd0, P}, 32'd17);
        checkOutput("holdIdle/done", {31'd0, done}, 32'd0);

        $display("[TB] extremes");
        runOp("maxAll", 31, 63, 63);
        runOp("qZero", 0, 63, 5);
        runOp("mZero", 31, 0, 0);

        $display("[TB] start held, operands changed mid-run");
        @(negedge clk);
        q = 3'd3;
        M = 6'd3;
        R = 6'd2;
        start = 1'b1;
        k1 = cycleCount + 1;
        repeat (2) @(negedge clk);
        q = 5'd2;
        M = 6'd7;
        R = 6'd6;
        waitDone("held1", d1, bc);
        checkOutput("held1/P", {21'd0, P}, refP(3, 3, 2));
        checkOutput("held1/latency", d1 - k1, N);
        @(negedge clk);
        checkOutput("held1/donePulse", {31'd0, done}, 32'd0);
        checkOutput("held1/Phold", {21'd0, P}, refP(3, 3, 2));
        waitDone("held2", d2, bc);
        start = 1'b0;
        checkOutput("held2/P", {21'd0, P}, refP(2, 7, 6));
        checkOutput("held2/spacing", d2 - d1, N + 1);
        @(negedge clk);
        checkOutput("held2/idleAfter", {31'd0, busy}, 32'd0);

        $display("[TB] start while busy is ignored");
        applyStimulus(5'd2, 6'd7, 6'd6, k1);
        q = 5'd31;
        M = 6'd63;
        R = 6'd63;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        waitDone("ignore", d1, bc);
        checkOutput("ignore/P", {21'd0, P}, refP(2, 7, 6));
        checkOutput("ignore/latency", d1 - k1, N);
        @(negedge clk);
        checkOutput("ignore/busyAfter", {31'd0, busy}, 32'd0);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(5'd31, 6'd63, 6'd63, k1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midReset/P", {21'd0, P}, 32'd0);
        checkOutput("midReset/busy", {31'd0, busy}, 32'd0);
        checkOutput("midReset/done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("midReset/noDone", doneSeen, 0);
        checkOutput("midReset/Pzero", {21'd0, P}, 32'd0);
        runOp("afterReset", 3, 3, 2);

        $display("[TB] randomized operands");
        for (int i = 0; i < 10; i++) begin
            qv = int'($urandom_range(0, (1 << N) - 1));
            mv = int'($urandom_range(0, (1 << (N + 1)) - 1));
            rv = int'($urandom_range(0, (1 << (N + 1)) - 1));
            runOp($sformatf("rand%0d", i), qv, mv, rv);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
